cdr_tx_symbol_gen: RTL and testbench
====================================

// Module: cdr_tx_symbol_gen
// PURPOSE
//  Test-symbol transmitter paired with the CDR receiver: drives the signed 8-bit sample stream (y_n) the CDR consumes.
//  - An NCO sets the symbol rate, so a programmable frequency offset against the receiver clock can be applied.
//  - Sends a fixed alternating preamble, then payload: a PRBS7 stream or user bytes through a valid/ready handshake.
// PARAMETERS
//  AMP           64  outer symbol magnitude (signed 8-bit, 1..127)
//  PREAMBLE_SYMS 16  number of alternating preamble symbols (1..255)
//  ACC_W         32  NCO phase-accumulator width
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous active-high reset
//  en          in   1      clock enable; low freezes NCO, FSM, counters and outputs
//  fcw         in   ACC_W  NCO frequency control word; symbol rate = f_clk*fcw/2^ACC_W
//  start       in   1      pulse: leave IDLE and begin preamble
//  stop        in   1      pulse: return to IDLE
//  mode_prbs   in   1      1 = PRBS7 payload, 0 = byte payload; sampled at start
//  byte_data   in   8      payload byte, sent MSB first
//  byte_valid  in   1      byte_data valid
//  byte_ready  out  1      1-deep holding buffer empty
//  sym_tick    out  1      one-cycle pulse on each new symbol
//  y_n         out  8      signed transmitted sample, held between ticks
//  tx_state    out  2      0 IDLE, 1 PREAMBLE, 2 PAYLOAD
//  underrun    out  1      sticky: payload symbol needed but no byte available
// BEHAVIOUR
//  Reset: acc=0, FSM=IDLE, y_n=0, sym_tick=0, byte_ready=1, underrun=0, holding buffer and shift register empty, LFSR=7'h7F.
//  NCO: outside IDLE with en=1, acc <= acc+fcw each clk; carry-out registers into sym_tick. fcw=0 gives no ticks.
//  Timing: y_n and sym_tick update on the same edge, i.e. registered, 1 clk after the carry.
//  FSM:
//   - IDLE: start -> PREAMBLE. acc cleared; symbol counter cleared; mode_prbs latched; underrun cleared.
//   - PREAMBLE: each tick emits +AMP, -AMP, +AMP, ... (first symbol +AMP). After PREAMBLE_SYMS ticks -> PAYLOAD.
//   - PAYLOAD: continues until stop.
//   - Any non-IDLE state: stop -> IDLE next clk; y_n <= 0; shift register emptied.
//  Priority and edge cases:
//   - start and stop in the same cycle: stop wins.
//   - start while not IDLE: ignored.
//   - Holding buffer is not flushed on stop.
//  PRBS7: x^7+x^6+1, Fibonacci. Output bit = s[6]; shift in s[6]^s[5]. Advances once per bit consumed. Period 127.
//  Byte mode:
//   - Load the buffer when byte_valid && byte_ready.
//   - When the shift register is empty at a tick, it takes the buffer in the same cycle; the buffer frees that cycle.
//   - A buffer load and a buffer take in the same cycle are both honoured.
//   - Buffer empty at that tick: y_n <= 0 for the symbol, underrun <= 1, stay in PAYLOAD.
//  Mapping (PAM2): bit 1 -> +AMP, bit 0 -> -AMP. y_n is always in range; no saturation logic.
//  Reset asserted mid-operation returns everything to reset values immediately.
// CONFIGURATION
//  CDR_TX_PAM4_EN defined:
//   - Payload uses 2 bits/symbol, first bit = MSB.
//   - Gray mapping: 00->-AMP, 01->-AMP/3, 11->+AMP/3, 10->+AMP. AMP/3 is a truncated constant.
//   - Byte mode sends 4 symbols per byte; PRBS advances twice per symbol.
//   - Preamble stays +/-AMP.
//  Undefined: PAM2 only, 1 bit/symbol; the PAM4 mapping logic is absent.
// STRUCTURE
//  Package cdr_tx_pkg: tx_state_t enum (IDLE/PREAMBLE/PAYLOAD), PRBS7 seed, PAM4 Gray-to-level function.
//  Sub-module prbs7_lfsr: clk, rst, adv, bit_o; 7-bit LFSR seeded 7'h7F, reloaded on start.
//  Everything else (NCO, FSM, byte buffer, shifter, mapper) is in this module.
// TESTING
//  1. fcw=32'h4000_0000, PREAMBLE_SYMS=4, pulse start -> sym_tick every 4 clks; y_n = +64,-64,+64,-64; then tx_state=2.
//  2. mode_prbs=1, PAM2 -> first 7 payload symbols +64. Full 127-symbol sequence matches the reference LFSR and repeats.
//  3. Byte mode, push 8'hA5 before the preamble ends -> payload +64,-64,+64,-64,-64,+64,-64,+64.
//     byte_ready returns 1 after the first payload tick.
//  4. Byte mode, no byte supplied -> first payload symbol y_n=0, underrun=1. Stays set until the next start.
//  5. start and stop in the same cycle -> stays IDLE, y_n=0. Stop mid-payload -> IDLE next clk.
//     Async rst mid-payload -> all outputs at reset values before the next edge.
//  6. With CDR_TX_PAM4_EN: byte 8'h1B -> -64,-21,+64,+21. en=0 for 10 clks mid-stream -> y_n and acc frozen.

Source files
------------

// File: rtl/cdr_tx_pkg.sv
// cdr_tx_pkg: shared types, PRBS seed and PAM4 Gray level mapping for cdr_tx_symbol_gen.
package cdr_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2
    } tx_state_t;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    // Gray order 00,01,11,10 walks the levels bottom to top; amp/3 truncates.
    function automatic logic [7:0] pam4_level(input logic [1:0] g, input logic [7:0] amp);
        logic [7:0] a3;
        a3 = amp / 8'd3;
        return g == 2'b00 ? -amp : g == 2'b01 ? -a3 : g == 2'b11 ? a3 : amp;
    endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// prbs7_lfsr: Fibonacci x^7+x^6+1 generator, BITS output bits per advance (first bit in the MSB).
module prbs7_lfsr
    import cdr_tx_pkg::*;
#(
    parameter int BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            adv,
    output logic [BITS-1:0] bit_o
);

    logic [6:0] s;
    logic [6:0] s_adv;

    always_comb begin
        bit_o = '0;
        s_adv = s;
        for (int i = 0; i < BITS; i++) begin
            bit_o[BITS-1-i] = s_adv[6];
            s_adv = {s_adv[5:0], s_adv[6] ^ s_adv[5]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s <= PRBS7_SEED;
        else if (start)
            s <= PRBS7_SEED;
        else if (adv)
            s <= s_adv;
    end

endmodule

// File: rtl/cdr_tx_symbol_gen.sv
// cdr_tx_symbol_gen: NCO-paced test-symbol transmitter (preamble, then PRBS7 or byte payload).
// Define CDR_TX_PAM4_EN for 2-bit/symbol PAM4 Gray payload; default build is PAM2 only.
module cdr_tx_symbol_gen
    import cdr_tx_pkg::*;
#(
    parameter int AMP           = 64,
    parameter int PREAMBLE_SYMS = 16,
    parameter int ACC_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ACC_W-1:0] fcw,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_prbs,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             sym_tick,
    output logic [7:0]       y_n,
    output logic [1:0]       tx_state,
    output logic             underrun
);

`ifdef CDR_TX_PAM4_EN
    localparam int BPS = 2;
`else
    localparam int BPS = 1;
`endif
    localparam int         SPB      = 8 / BPS;
    localparam logic [7:0] AMP8     = 8'(AMP);
    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_SYMS - 1);

    tx_state_t      state, state_d;
    logic [ACC_W-1:0] acc, acc_d;
    logic [ACC_W:0] sum;
    logic [7:0]     pre_cnt, pre_cnt_d;
    logic           mode, mode_d;
    logic [7:0]     buf_q, buf_d;
    logic           buf_full, buf_full_d;
    logic [7:0]     sr, sr_d;
    logic [2:0]     sr_cnt, sr_cnt_d;
    logic [7:0]     y_q, y_d;
    logic           tick_q, tick_d;
    logic           und_q, und_d;
    logic           load, take;
    logic           lfsr_start, lfsr_adv;
    logic [BPS-1:0] prbs_bits;

    prbs7_lfsr #(.BITS(BPS)) u_prbs (
        .clk   (clk),
        .rst   (rst),
        .start (lfsr_start),
        .adv   (lfsr_adv),
        .bit_o (prbs_bits)
    );

    function automatic logic [7:0] map_sym(input logic [BPS-1:0] b);
`ifdef CDR_TX_PAM4_EN
        return pam4_level(b, AMP8);
`else
        return b[0] ? AMP8 : -AMP8;
`endif
    endfunction

    always_comb begin
        sum        = {1'b0, acc} + {1'b0, fcw};
        state_d    = state;
        acc_d      = acc;
        pre_cnt_d  = pre_cnt;
        mode_d     = mode;
        buf_d      = buf_q;
        sr_d       = sr;
        sr_cnt_d   = sr_cnt;
        y_d        = y_q;
        tick_d     = tick_q;
        und_d      = und_q;
        lfsr_start = 1'b0;
        lfsr_adv   = 1'b0;
        take       = 1'b0;
        load       = en && byte_valid && !buf_full;
        if (en && state == IDLE) begin
            if (start && !stop) begin
                state_d    = PREAMBLE;
                acc_d      = '0;
                pre_cnt_d  = '0;
                mode_d     = mode_prbs;
                und_d      = 1'b0;
                lfsr_start = 1'b1;
            end
        end else if (en && stop) begin
            state_d  = IDLE;
            y_d      = '0;
            tick_d   = 1'b0;
            sr_cnt_d = '0;
        end else if (en) begin
            acc_d  = sum[ACC_W-1:0];
            tick_d = sum[ACC_W];
            // The NCO carry is the symbol strobe; the new symbol lands with sym_tick.
            if (sum[ACC_W]) begin
                if (state == PREAMBLE) begin
                    y_d       = pre_cnt[0] ? -AMP8 : AMP8;
                    pre_cnt_d = pre_cnt + 8'd1;
                    state_d   = pre_cnt == PRE_LAST ? PAYLOAD : PREAMBLE;
                end else if (mode) begin
                    lfsr_adv = 1'b1;
                    y_d      = map_sym(prbs_bits);
                end else if (sr_cnt != 3'd0) begin
                    y_d      = map_sym(sr[7 -: BPS]);
                    sr_d     = sr << BPS;
                    sr_cnt_d = sr_cnt - 3'd1;
                end else if (buf_full) begin
                    take     = 1'b1;
                    y_d      = map_sym(buf_q[7 -: BPS]);
                    sr_d     = buf_q << BPS;
                    sr_cnt_d = 3'(SPB - 1);
                end else begin
                    y_d   = '0;
                    und_d = 1'b1;
                end
            end
        end
        buf_d      = load ? byte_data : buf_q;
        buf_full_d = load || (buf_full && !take);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            pre_cnt  <= '0;
            mode     <= 1'b0;
            buf_q    <= '0;
            buf_full <= 1'b0;
            sr       <= '0;
            sr_cnt   <= '0;
            y_q      <= '0;
            tick_q   <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            state    <= state_d;
            acc      <= acc_d;
            pre_cnt  <= pre_cnt_d;
            mode     <= mode_d;
            buf_q    <= buf_d;
            buf_full <= buf_full_d;
            sr       <= sr_d;
            sr_cnt   <= sr_cnt_d;
            y_q      <= y_d;
            tick_q   <= tick_d;
            und_q    <= und_d;
        end
    end

    assign y_n        = y_q;
    assign sym_tick   = tick_q;
    assign tx_state   = state;
    assign byte_ready = !buf_full;
    assign underrun   = und_q;

endmodule

// File: tb/tb_cdr_tx_symbol_gen.sv
// tb_cdr_tx_symbol_gen: directed + randomized checks of cdr_tx_symbol_gen against a symbol-level model.
module tb_cdr_tx_symbol_gen;

    localparam int AMP = 64;
    localparam int PRE = 4;
`ifdef CDR_TX_PAM4_EN
    localparam int BPS = 2;
`else
    localparam int BPS = 1;
`endif
    localparam int SPB = 8 / BPS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [31:0] fcw = 32'h4000_0000;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode_prbs = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        sym_tick;
    logic [7:0]  y_n;
    logic [1:0]  tx_state;
    logic        underrun;

    int passed = 0;
    int total = 0;
    bit prbs_ref[127];

    cdr_tx_symbol_gen #(.AMP(AMP), .PREAMBLE_SYMS(PRE), .ACC_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fcw        (fcw),
        .start      (start),
        .stop       (stop),
        .mode_prbs  (mode_prbs),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .sym_tick   (sym_tick),
        .y_n        (y_n),
        .tx_state   (tx_state),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int sym_level(input int v);
`ifdef CDR_TX_PAM4_EN
        case (v)
            0: return -AMP;
            1: return -(AMP / 3);
            3: return AMP / 3;
            default: return AMP;
        endcase
`else
        return v != 0 ? AMP : -AMP;
`endif
    endfunction

    function automatic int prbs_sym(input int k);
        int v = 0;
        for (int j = 0; j < BPS; j++) v = v * 2 + int'(prbs_ref[(k * BPS + j) % 127]);
        return sym_level(v);
    endfunction

    function automatic int byte_sym(input logic [7:0] b, input int i);
        int v = 0;
        for (int j = 0; j < BPS; j++) v = v * 2 + int'(b[7 - (i * BPS + j)]);
        return sym_level(v);
    endfunction

    // Clock count from start to the m-th symbol: first n with n*fcw >= m*2^32.
    function automatic longint t_of(input int m);
        return ((longint'(m) << 32) + longint'(fcw) - 1) / longint'(fcw);
    endfunction

    task automatic wait_tick(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!sym_tick && gap < 64);
        if (!sym_tick) check("tick_timeout", sym_tick, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    initial begin
        int gap;
        int m;
        logic [7:0] q[$];
        for (int k = 0; k < 7; k++) prbs_ref[k] = 1'b1;
        for (int k = 7; k < 127; k++) prbs_ref[k] = prbs_ref[k-7] ^ prbs_ref[k-6];

        repeat (3) @(negedge clk);
        check("rst_y", $signed(y_n), 0);
        check("rst_tick", sym_tick, 0);
        check("rst_state", tx_state, 0);
        check("rst_ready", byte_ready, 1);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // Preamble at quarter rate, byte mode with no data supplied
        fcw = 32'h4000_0000;
        mode_prbs = 1'b0;
        pulse_start();
        check("state_pre", tx_state, 1);
        for (int i = 0; i < PRE; i++) begin
            wait_tick(gap);
            check("pre_gap", gap, 32'(t_of(i + 1) - t_of(i)));
            check("pre_sym", $signed(y_n), (i % 2) != 0 ? -AMP : AMP);
        end
        check("state_payload", tx_state, 2);
        wait_tick(gap);
        check("underrun_sym", $signed(y_n), 0);
        check("underrun_flag", underrun, 1);
        check("underrun_state", tx_state, 2);
        wait_tick(gap);
        check("underrun_sticky", underrun, 1);

        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_state", tx_state, 0);
        check("stop_y", $signed(y_n), 0);
        check("stop_underrun_kept", underrun, 1);

        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        check("startstop_state", tx_state, 0);
        repeat (8) @(negedge clk);
        check("idle_state", tx_state, 0);
        check("idle_y", $signed(y_n), 0);
        check("idle_tick", sym_tick, 0);

        // PRBS payload at a random rate, two full periods, with an en freeze
        fcw = $urandom_range(32'h2000_0000, 32'h7FFF_FFFF);
        mode_prbs = 1'b1;
        pulse_start();
        check("prbs_underrun_clr", underrun, 0);
        m = 0;
        for (int i = 0; i < PRE; i++) begin
            wait_tick(gap);
            m++;
            check("prbs_pre_gap", gap, 32'(t_of(m) - t_of(m - 1)));
            check("prbs_pre_sym", $signed(y_n), (i % 2) != 0 ? -AMP : AMP);
        end
        for (int k = 0; k < 254; k++) begin
            wait_tick(gap);
            m++;
            check("prbs_gap", gap, 32'(t_of(m) - t_of(m - 1)));
            check("prbs_sym", $signed(y_n), prbs_sym(k));
            if (k == 100) begin
                en = 1'b0;
                repeat (10) @(negedge clk);
                check("freeze_y", $signed(y_n), prbs_sym(k));
                check("freeze_tick", sym_tick, 1);
                check("freeze_state", tx_state, 2);
                en = 1'b1;
            end
        end
        push(8'h3C);
        check("prbs_buf_held", byte_ready, 0);

        #2 rst = 1'b1;
        #1;
        check("arst_y", $signed(y_n), 0);
        check("arst_tick", sym_tick, 0);
        check("arst_state", tx_state, 0);
        check("arst_ready", byte_ready, 1);
        check("arst_underrun", underrun, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Byte payload: directed first byte, then random bytes streamed back to back
        fcw = 32'h4000_0000;
        mode_prbs = 1'b0;
`ifdef CDR_TX_PAM4_EN
        q.push_back(8'h1B);
`else
        q.push_back(8'hA5);
`endif
        for (int j = 0; j < 5; j++) q.push_back(8'($urandom));
        pulse_start();
        push(q[0]);
        check("byte_ready_full", byte_ready, 0);
        for (int i = 0; i < PRE; i++) begin
            wait_tick(gap);
            check("byte_pre_sym", $signed(y_n), (i % 2) != 0 ? -AMP : AMP);
        end
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < SPB; i++) begin
                wait_tick(gap);
                check("byte_sym", $signed(y_n), byte_sym(q[j], i));
                if (i == 0) begin
                    check("byte_ready_free", byte_ready, 1);
                    if (j < 5) push(q[j+1]);
                end
            end
        end
        check("byte_no_underrun", underrun, 0);
        wait_tick(gap);
        check("byte_drain_y", $signed(y_n), 0);
        check("byte_drain_underrun", underrun, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("byte_stop_state", tx_state, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
